// File: rtl/fd_pipe_if.sv
// Bus interface for fd_pipe: pipeline control, data in and data/valid/occupancy out.
// Optional FD_PIPE_PARITY_EN adds the sticky PERR flag.
interface fd_pipe_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
);
  localparam int unsigned CW = $clog2(D + 1);

  logic          CE;
  logic          FLUSH;
  logic [W-1:0]  I;
  logic          IV;
  logic [W-1:0]  O;
  logic          OV;
  logic [CW-1:0] CNT;
`ifdef FD_PIPE_PARITY_EN
  logic          PERR;
`endif

`ifdef FD_PIPE_PARITY_EN
  modport master (output CE, FLUSH, I, IV, input O, OV, CNT, PERR);
  modport slave  (input CE, FLUSH, I, IV, output O, OV, CNT, PERR);
`else
  modport master (output CE, FLUSH, I, IV, input O, OV, CNT);
  modport slave  (input CE, FLUSH, I, IV, output O, OV, CNT);
`endif
endinterface

// File: rtl/fd_pipe.sv
// W-bit, D-stage stallable delay line with per-stage valid, flush and occupancy count.
// Optional macro FD_PIPE_PARITY_EN adds per-stage parity and the sticky PERR output.
module fd_pipe #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input  logic     CK,
  input  logic     CLR_N,
  fd_pipe_if.slave bus
);
  localparam int unsigned CW  = $clog2(D + 1);
  localparam int unsigned CW1 = CW + 1;

  logic [W-1:0]  stage_q [D];
  logic [W-1:0]  stage_d [D];
  logic [D-1:0]  v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_sum;

  // Next-state: flush beats advance; otherwise hold
  always_comb begin
    stage_d = stage_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    cnt_sum = CW1'({1'b0, cnt_q}) + CW1'(bus.IV) - CW1'(v_q[D-1]);
    if (bus.FLUSH) begin
      v_d   = '0;
      cnt_d = '0;
    end else if (bus.CE) begin
      stage_d[0] = bus.I;
      v_d[0]     = bus.IV;
      for (int unsigned k = 1; k < D; k++) begin
        stage_d[k] = stage_q[k-1];
        v_d[k]     = v_q[k-1];
      end
      cnt_d = CW'(cnt_sum);
    end
  end

  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int unsigned k = 0; k < D; k++) stage_q[k] <= '0;
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < D; k++) stage_q[k] <= stage_d[k];
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.O   = stage_q[D-1];
  assign bus.OV  = v_q[D-1];
  assign bus.CNT = cnt_q;

`ifdef FD_PIPE_PARITY_EN
  logic [D-1:0] p_q, p_d;
  logic         perr_q, perr_d;

  // Parity shifts with data; the flag latches any valid-output mismatch until flush
  always_comb begin
    p_d    = p_q;
    perr_d = perr_q | (v_q[D-1] & ((^stage_q[D-1]) != p_q[D-1]));
    if (bus.FLUSH) begin
      perr_d = 1'b0;
    end else if (bus.CE) begin
      p_d[0] = ^bus.I;
      for (int unsigned k = 1; k < D; k++) p_d[k] = p_q[k-1];
    end
  end

  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      p_q    <= '0;
      perr_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      perr_q <= perr_d;
    end
  end

  assign bus.PERR = perr_q;
`endif
endmodule

// File: doc/fd_pipe.md
Name: fd_pipe

Overview:
- Parametrised successor to the fixed 8-bit always-enabled register: a W-bit, D-stage register pipeline (delay line).
- Adds a clock enable (stall), a per-stage valid bit, a synchronous flush, and an occupancy count.
- Used wherever datapath signals need a fixed, stallable latency to match a parallel path, e.g. aligning sample data with control in the acquisition chain.

Parameters:
- W, 8, data width in bits (W >= 1).
- D, 4, pipeline depth in stages (D >= 1); latency in enabled cycles.
- CW, $clog2(D+1), width of the occupancy count; derived, not overridden.

Ports:
- CK  input  1  clock, rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- CE  input  1  clock enable; 1 = advance the pipeline, 0 = hold all stages.
- FLUSH  input  1  synchronous flush of all valid bits.
- I  input  W  data in.
- IV  input  1  data-in valid.
- O  output  W  data out; equals the last stage.
- OV  output  1  data-out valid; equals the last-stage valid bit.
- CNT  output  CW  number of stages currently holding valid data, 0..D.

Behaviour:
- Reset:
  - CLR_N = 0 asynchronously clears all stage data to 0, all valid bits to 0, and CNT to 0.
  - Release is synchronous to CK. The first update occurs on the first rising edge with CLR_N = 1.
- Storage: stage[0..D-1] (W bits each) and v[0..D-1]. O = stage[D-1] and OV = v[D-1], both taken directly from registers with no combinational path from the inputs.
- Advance (CE = 1, FLUSH = 0), at each rising edge:
  - stage[0] <= I and v[0] <= IV.
  - stage[k] <= stage[k-1] and v[k] <= v[k-1] for k = 1..D-1.
- Hold (CE = 0, FLUSH = 0): all registers and CNT keep their values. O and OV are stable.
- Latency: a word presented with IV = 1 on CE-edge n appears on O with OV = 1 after exactly D CE-edges. Edges with CE = 0 do not count.
- Flush (FLUSH = 1):
  - Takes priority over CE. At the next edge all v[] <= 0 and CNT <= 0.
  - Stage data is not cleared; the data bits are don't-care once invalid.
  - I/IV on that edge are discarded, even if CE = 1.
- Occupancy:
  - On an advance edge, CNT <= CNT + IV - v[D-1], computed at width CW + 1 and truncated.
  - CNT never exceeds D and never underflows; the bench asserts CNT == popcount(v) every cycle.
  - Simultaneous IV = 1 and v[D-1] = 1 leaves CNT unchanged.
- Invalid data: bubbles (IV = 0) propagate like data, with their data field still shifted. Downstream must qualify O with OV.
- D = 1: the block degenerates to a single register with CE, valid, and flush. CNT is 1 bit.
- Reset mid-stream: all in-flight valid words are lost immediately. No output is produced for them after release.

Optional Feature:
- Macro: FD_PIPE_PARITY_EN.
- When defined:
  - Each stage carries an extra parity bit. p[0] <= ^I on advance, and the parity bits shift with the data.
  - Adds output PERR (1 bit), a sticky flag:
    - Set on any edge where OV = 1 and ^O != p[D-1].
    - Cleared by CLR_N = 0 or FLUSH = 1.
    - Reset value 0.
- When undefined: no parity storage and no PERR port; the behaviour is otherwise identical.

Test Plan:
- Reset: hold CLR_N = 0 with random I/IV/CE -> O = 0, OV = 0, CNT = 0 throughout. Asserting CLR_N = 0 asynchronously mid-cycle clears them before the next edge.
- Latency, W = 8, D = 4, CE = 1: drive I = 0x11,0x22,0x33,0x44,0x55 with IV = 1 for 5 cycles, then IV = 0 -> O/OV show 0x11..0x55 valid on cycles 4..8 after the first input. CNT goes 1,2,3,4,4,3,2,1,0.
- Stall: same stream with CE = 0 for 3 cycles after the second word -> the output sequence is unchanged but each word is delayed by 3 cycles. O, OV and CNT stay frozen during the stall.
- Flush: fill the pipe with 4 valid words (CNT = 4), then FLUSH = 1 with CE = 1 and IV = 1, I = 0x99 -> next cycle OV = 0 and CNT = 0. 0x99 never appears valid on O.
- Bubbles and boundaries: IV pattern 1,0,1,0,1 with D = 1 -> OV echoes the pattern one cycle later. CNT toggles 1,0,1,0,1, and CNT == popcount(v) holds at every edge.
- Parity (macro defined): force p[D-1] inverted while OV = 1 -> PERR = 1 at the next edge and stays 1. FLUSH = 1 -> PERR = 0.
